// File: rtl/serial_magnitude_compare_pkg.sv
// rtl/serial_magnitude_compare_pkg.sv - shared codes, FSM state type and cascade normalisation
package serial_cmp_pkg;

  localparam logic [2:0] CMP_GT   = 3'b100;
  localparam logic [2:0] CMP_LT   = 3'b010;
  localparam logic [2:0] CMP_EQ   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  // Only the two strict codes survive; anything else (including 000 and
  // multi-hot patterns) counts as "equal so far".
  function automatic logic [2:0] cmp_norm(input logic [2:0] code);
    case (code)
      CMP_GT:  return CMP_GT;
      CMP_LT:  return CMP_LT;
      default: return CMP_EQ;
    endcase
  endfunction

endpackage

// File: rtl/serial_magnitude_compare_if.sv
// rtl/serial_magnitude_compare_if.sv - start/operand/result bundle for the serial comparator
interface serial_magnitude_compare_if #(
  parameter int WIDTH = 16
);

  logic             iStart;
  logic [WIDTH-1:0] iData_a;
  logic [WIDTH-1:0] iData_b;
  logic [2:0]       iData;
  logic             oBusy;
  logic             oDone;
  logic [2:0]       oData;

  // Requester side: issues operands, watches the result.
  modport master (
    output iStart, iData_a, iData_b, iData,
    input  oBusy, oDone, oData
  );

  // Comparator side.
  modport slave (
    input  iStart, iData_a, iData_b, iData,
    output oBusy, oDone, oData
  );

endinterface

// File: rtl/serial_magnitude_compare_nibble.sv
// rtl/serial_magnitude_compare_nibble.sv - combinational 4-bit cascade comparator stage
module nibble_cascade_cmp
  import serial_cmp_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic [2:0] i_casc,
  output logic [2:0] o_code
);

  logic [2:0] w_casc;

  assign w_casc = cmp_norm(i_casc);

  // A differing nibble decides on its own; equal nibbles pass the lower result through.
  always_comb begin
    o_code = w_casc;
    if (i_a > i_b) begin
      o_code = CMP_GT;
    end else if (i_a < i_b) begin
      o_code = CMP_LT;
    end
  end

endmodule

// File: rtl/serial_magnitude_compare.sv
// rtl/serial_magnitude_compare.sv - nibble-serial unsigned magnitude comparator, LSB nibble first
module serial_magnitude_compare
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                      iClk,
  input  logic                      iRst_n,
  serial_magnitude_compare_if.slave bus
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(NIBBLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [2:0]       r_c;
  logic [CW-1:0]    r_k;
  logic             r_busy;
  logic             r_done;
  logic [2:0]       r_data;

  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic [2:0]       w_stage;

  nibble_cascade_cmp u_stage (
    .i_a    (r_sa[3:0]),
    .i_b    (r_sb[3:0]),
    .i_casc (r_c),
    .o_code (w_stage)
  );

  // State register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: start only from IDLE, leave RUN after the most significant nibble.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.iStart) w_state_nxt = S_RUN;
      S_RUN:  if (r_k == K_LAST) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state.
  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    w_last = 1'b0;
    case (r_state)
      S_IDLE: w_load = bus.iStart;
      S_RUN: begin
        w_step = 1'b1;
        w_last = (r_k == K_LAST);
      end
      default: ;
    endcase
  end

  // Operand shifters, cascade register, counter and registered outputs.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_c    <= CMP_EQ;
      r_k    <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_data <= CMP_NONE;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_sa   <= bus.iData_a;
        r_sb   <= bus.iData_b;
        r_c    <= cmp_norm(bus.iData);
        r_k    <= '0;
        r_busy <= 1'b1;
      end else if (w_step) begin
        if (w_last) begin
          r_data <= w_stage;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end else begin
          r_c  <= w_stage;
          r_sa <= r_sa >> 4;
          r_sb <= r_sb >> 4;
          r_k  <= r_k + CW'(1);
        end
      end
    end
  end

  assign bus.oBusy = r_busy;
  assign bus.oDone = r_done;
  assign bus.oData = r_data;

endmodule

// File: tb/tb_serial_magnitude_compare.sv
// tb/tb_serial_magnitude_compare.sv - scoreboard bench for serial_magnitude_compare at WIDTH=16
module tb_serial_magnitude_compare;

  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [2:0] sb_q[$];

  serial_magnitude_compare_if #(.WIDTH(W)) bus ();

  serial_magnitude_compare #(.WIDTH(W)) dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [2:0] cin);
    if (a > b) return 3'b100;
    if (a < b) return 3'b010;
    if (cin == 3'b100 || cin == 3'b010) return cin;
    return 3'b001;
  endfunction

  // Called at posedge+1; start is accepted on the next edge, returns at that edge +1.
  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] cin, input bit push);
    bus.iStart  = 1'b1;
    bus.iData_a = a;
    bus.iData_b = b;
    bus.iData   = cin;
    if (push) sb_q.push_back(model(a, b, cin));
    @(posedge clk);
    #1;
    bus.iStart  = 1'b0;
    bus.iData_a = $urandom();
    bus.iData_b = $urandom();
    bus.iData   = 3'($urandom());
  endtask

  task automatic wait_done(input int limit, output int n_cyc, output int busy_cnt,
                           output bit seen);
    busy_cnt = bus.oBusy ? 1 : 0;
    seen     = 1'b0;
    n_cyc    = 0;
    for (int n = 1; n <= limit; n++) begin
      @(posedge clk);
      #1;
      if (bus.oDone) begin
        seen  = 1'b1;
        n_cyc = n;
        break;
      end
      if (bus.oBusy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.oBusy !== 1'b0 || bus.oDone !== 1'b0 || bus.oData !== 3'b000) begin
      errors++;
      $display("FAIL reset_in: busy=%b done=%b data=%b expected 0 0 000", bus.oBusy, bus.oDone, bus.oData);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.oBusy !== 1'b0 || bus.oDone !== 1'b0 || bus.oData !== 3'b000) begin
      errors++;
      $display("FAIL reset_out: busy=%b done=%b data=%b expected 0 0 000", bus.oBusy, bus.oDone, bus.oData);
    end
  endtask

  task automatic run_one(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] cin, input bit chk_busy);
    int n, bc;
    bit seen;
    logic [2:0] exp;
    do_start(a, b, cin, 1'b1);
    wait_done(20, n, bc, seen);
    exp = sb_q.pop_front();
    checks++;
    if (!seen || n !== 4) begin
      errors++;
      $display("FAIL %s_latency: seen=%0d cycles=%0d expected 4", name, seen, n);
    end
    checks++;
    if (bus.oData !== exp) begin
      errors++;
      $display("FAIL %s_data: got %b expected %b", name, bus.oData, exp);
    end
    if (chk_busy) begin
      checks++;
      if (bc !== 4) begin
        errors++;
        $display("FAIL %s_busy: busy cycles %0d expected 4", name, bc);
      end
    end
  endtask

  task automatic test_equal();
    run_one("equal", 16'h1234, 16'h1234, 3'b001, 1'b1);
  endtask

  task automatic test_msb_dominates();
    run_one("msb", 16'h8000, 16'h7FFF, 3'b001, 1'b0);
  endtask

  task automatic test_lsb_decides();
    run_one("lsb", 16'h1230, 16'h1231, 3'b001, 1'b0);
  endtask

  task automatic test_cascade_in();
    logic [2:0] cins[3];
    cins = '{3'b010, 3'b100, 3'b110};
    for (int i = 0; i < 3; i++) run_one("cascade", 16'hABCD, 16'hABCD, cins[i], 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_one("random", W'($urandom()), W'($urandom()), 3'($urandom()), 1'b1);
  endtask

  task automatic test_start_held();
    int n, bc;
    bit seen, early;
    logic [2:0] exp;
    do_start(16'h0001, 16'h0002, 3'b001, 1'b1);
    bus.iStart  = 1'b1;
    bus.iData_a = 16'hFFFF;
    bus.iData_b = 16'h0000;
    early = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (bus.oDone) early = 1'b1;
    end
    bus.iStart = 1'b0;
    checks++;
    if (early) begin
      errors++;
      $display("FAIL held_early: oDone seen %0d expected 0", early);
    end
    wait_done(4, n, bc, seen);
    exp = sb_q.pop_front();
    checks++;
    if (!seen || n !== 1 || bus.oData !== exp) begin
      errors++;
      $display("FAIL held_data: seen=%0d cycles=%0d data=%b expected 1 1 %b", seen, n, bus.oData, exp);
    end
    wait_done(8, n, bc, seen);
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL held_restart: extra oDone after %0d cycles expected none", n);
    end
  endtask

  task automatic test_back_to_back();
    int n, bc;
    bit seen;
    logic [2:0] exp;
    do_start(16'h0005, 16'h0003, 3'b001, 1'b1);
    wait_done(20, n, bc, seen);
    exp = sb_q.pop_front();
    checks++;
    if (!seen || bus.oData !== exp) begin
      errors++;
      $display("FAIL b2b_first: seen=%0d data=%b expected 1 %b", seen, bus.oData, exp);
    end
    do_start(16'hFFFF, 16'h0000, 3'b010, 1'b1);
    wait_done(20, n, bc, seen);
    exp = sb_q.pop_front();
    checks++;
    if (!seen || n !== 4) begin
      errors++;
      $display("FAIL b2b_latency: seen=%0d cycles=%0d expected 4", seen, n);
    end
    checks++;
    if (bus.oData !== exp || exp !== 3'b100) begin
      errors++;
      $display("FAIL b2b_data: got %b expected 100", bus.oData);
    end
  endtask

  task automatic test_reset_mid();
    int n, bc;
    bit seen;
    do_start(16'h4321, 16'h1234, 3'b001, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.oBusy !== 1'b0 || bus.oDone !== 1'b0 || bus.oData !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b data=%b expected 0 0 000", bus.oBusy, bus.oDone, bus.oData);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_done(8, n, bc, seen);
    checks++;
    if (seen || bus.oBusy !== 1'b0 || bus.oData !== 3'b000) begin
      errors++;
      $display("FAIL mid_after: done_seen=%0d busy=%b data=%b expected 0 0 000", seen, bus.oBusy, bus.oData);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.iStart  = 1'b0;
    bus.iData_a = '0;
    bus.iData_b = '0;
    bus.iData   = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_equal();
    test_msb_dominates();
    test_lsb_decides();
    test_cascade_in();
    test_start_held();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
